// File: rtl/bnn_pkg.sv
// Shared constants, sample type, FSM encoding and signed max helper for the
// binary-net pooling stage.
package bnn_pkg;

  localparam int unsigned CH = 6;
  localparam int unsigned DW = 16;

  typedef logic signed [DW-1:0] sample_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_linebuf.sv
// Half-row line buffer: one entry per horizontal pair, shared read/write
// address, registered write and combinational read.
module pool_linebuf #(
  parameter int unsigned DEPTH = 12,
  parameter int unsigned W     = 96,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/maxpool_bin.sv
// Streaming 2x2/stride-2 max pooling over six lockstep channels, followed by
// per-channel signed thresholding into activation bits.
module maxpool_bin
  import bnn_pkg::*;
#(
  parameter int unsigned IMG_W = 24,
  parameter int unsigned IMG_H = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CH*DW-1:0] thresh,
  input  logic [CH-1:0]    ivalid,
  input  logic [CH-1:0]    in_done,
  input  logic [DW-1:0]    din_0,
  input  logic [DW-1:0]    din_1,
  input  logic [DW-1:0]    din_2,
  input  logic [DW-1:0]    din_3,
  input  logic [DW-1:0]    din_4,
  input  logic [DW-1:0]    din_5,
  output logic             ovalid,
  output logic [CH-1:0]    dout_bin,
  output logic [CH*DW-1:0] dout_pool,
  output logic             frame_done,
  output logic             err
);

  localparam int unsigned HW = IMG_W / 2;
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned AW = (HW > 1) ? $clog2(HW) : 1;

  state_e          state_q;
  logic [CW-1:0]   col_q;
  logic [RW-1:0]   row_q;
  logic            ovalid_q, fdone_q, err_q;

  sample_t         din_a [CH];
  logic [CH*DW-1:0] lb_wdata, lb_rdata;

  logic run, samp, last_col, last_row, fin, abort, acc, partial, pool_fire, lb_we;

  assign din_a[0] = din_0;
  assign din_a[1] = din_1;
  assign din_a[2] = din_2;
  assign din_a[3] = din_3;
  assign din_a[4] = din_4;
  assign din_a[5] = din_5;

  // start always wins; a completing sample outranks a simultaneous in_done
  assign run       = (state_q == RUN) && !start;
  assign samp      = run && (ivalid == '1);
  assign last_col  = (col_q == CW'(IMG_W - 1));
  assign last_row  = (row_q == RW'(IMG_H - 1));
  assign fin       = samp && last_col && last_row;
  assign abort     = run && (in_done == '1) && !fin;
  assign acc       = samp && !abort;
  assign partial   = run && (ivalid != '0) && (ivalid != '1);
  assign pool_fire = acc && col_q[0] && row_q[0];
  assign lb_we     = acc && col_q[0] && !row_q[0];

  pool_linebuf #(
    .DEPTH (HW),
    .W     (CH * DW),
    .AW    (AW)
  ) u_linebuf (
    .clk     (clk),
    .we_i    (lb_we),
    .addr_i  (AW'(col_q >> 1)),
    .wdata_i (lb_wdata),
    .rdata_o (lb_rdata)
  );

  // Frame control: state, raster counters, valid/done pulses, sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      ovalid_q <= 1'b0;
      fdone_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ovalid_q <= pool_fire;
      fdone_q  <= fin;
      if (start) begin
        state_q <= RUN;
        col_q   <= '0;
        row_q   <= '0;
        err_q   <= 1'b0;
      end else begin
        if (partial || abort) err_q <= 1'b1;
        case (state_q)
          RUN: begin
            if (abort)    state_q <= IDLE;
            else if (fin) state_q <= DONE;
          end
          DONE:    state_q <= IDLE;
          default: state_q <= state_q;
        endcase
        if (acc) begin
          if (last_col) begin
            col_q <= '0;
            row_q <= last_row ? '0 : row_q + RW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    sample_t hold_q, thr_q, pool_q, hmax, pooled;
    logic    bin_q;

    assign hmax     = smax(hold_q, din_a[g]);
    assign pooled   = smax(sample_t'(lb_rdata[g*DW +: DW]), hmax);
    assign lb_wdata[g*DW +: DW] = hmax;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold_q <= '0;
        thr_q  <= '0;
        pool_q <= '0;
        bin_q  <= 1'b0;
      end else begin
        if (start) thr_q <= thresh[g*DW +: DW];
        if (acc && !col_q[0]) hold_q <= din_a[g];
        if (pool_fire) begin
          pool_q <= pooled;
          bin_q  <= (pooled >= thr_q);
        end
      end
    end

    assign dout_pool[g*DW +: DW] = pool_q;
    assign dout_bin[g]           = bin_q;
  end

  assign ovalid     = ovalid_q;
  assign frame_done = fdone_q;
  assign err        = err_q;

endmodule

// File: tb/tb_maxpool_bin.sv
// Directed + randomized bench for maxpool_bin: a 4x4 instance for directed
// frames and a 24x24 instance for the gapped random frame and async reset.
module tb_maxpool_bin;

  typedef struct packed {
    logic [95:0] pool;
    logic [5:0]  bin;
    logic        fd;
  } out_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [95:0] thresh = '0;
  logic [5:0]  ivalid = '0;
  logic [5:0]  in_done = '0;
  logic [15:0] din [6] = '{default: '0};

  logic        ov4, fd4, err4, ov24, fd24, err24;
  logic [5:0]  bin4, bin24;
  logic [95:0] pool4, pool24;

  int   fr [24][24][6];
  int   thr [6];
  out_t eq [$];
  out_t q4 [$];
  out_t q24 [$];
  int   ramp_exp [4] = '{5, 7, 13, 15};
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  maxpool_bin #(.IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .thresh(thresh), .ivalid(ivalid),
    .in_done(in_done), .din_0(din[0]), .din_1(din[1]), .din_2(din[2]),
    .din_3(din[3]), .din_4(din[4]), .din_5(din[5]), .ovalid(ov4),
    .dout_bin(bin4), .dout_pool(pool4), .frame_done(fd4), .err(err4)
  );

  maxpool_bin #(.IMG_W(24), .IMG_H(24)) dut24 (
    .clk(clk), .rst(rst), .start(start), .thresh(thresh), .ivalid(ivalid),
    .in_done(in_done), .din_0(din[0]), .din_1(din[1]), .din_2(din[2]),
    .din_3(din[3]), .din_4(din[4]), .din_5(din[5]), .ovalid(ov24),
    .dout_bin(bin24), .dout_pool(pool24), .frame_done(fd24), .err(err24)
  );

  // Capture every output pulse of both instances
  always @(negedge clk) begin
    if (ov4 === 1'b1)  q4.push_back('{pool: pool4, bin: bin4, fd: fd4});
    if (ov24 === 1'b1) q24.push_back('{pool: pool24, bin: bin24, fd: fd24});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rnd16();
    logic signed [15:0] s;
    s = 16'($urandom);
    return int'(s);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic arm();
    for (int k = 0; k < 6; k++) thresh[k*16 +: 16] = 16'(thr[k]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int r, input int c, input logic [5:0] v);
    ivalid = v;
    for (int k = 0; k < 6; k++) din[k] = 16'(fr[r][c][k]);
    @(negedge clk);
    ivalid = '0;
  endtask

  task automatic play(input int w, input int h, input int gap);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        if (int'($urandom_range(99)) < gap) idle(int'($urandom_range(2, 1)));
        send(r, c, 6'h3f);
      end
  endtask

  // Reference: each output is the max of a 2x2 window, raster order of windows
  task automatic model(input int w, input int h);
    out_t e;
    int   m;
    eq.delete();
    for (int pr = 0; pr < h / 2; pr++)
      for (int pc = 0; pc < w / 2; pc++) begin
        e = '0;
        for (int k = 0; k < 6; k++) begin
          m = fr[2*pr][2*pc][k];
          if (fr[2*pr][2*pc+1][k] > m)   m = fr[2*pr][2*pc+1][k];
          if (fr[2*pr+1][2*pc][k] > m)   m = fr[2*pr+1][2*pc][k];
          if (fr[2*pr+1][2*pc+1][k] > m) m = fr[2*pr+1][2*pc+1][k];
          e.pool[k*16 +: 16] = 16'(m);
          e.bin[k] = (m >= thr[k]);
        end
        e.fd = (pr == h / 2 - 1) && (pc == w / 2 - 1);
        eq.push_back(e);
      end
  endtask

  task automatic cmp(input string tag, input bit big);
    out_t got [$];
    if (big) begin got = q24; q24.delete(); end
    else     begin got = q4;  q4.delete();  end
    chk({tag, "_count"}, 128'(got.size()), 128'(eq.size()));
    for (int i = 0; i < got.size() && i < eq.size(); i++) begin
      chk($sformatf("%s_pool%0d", tag, i), 128'(got[i].pool), 128'(eq[i].pool));
      chk($sformatf("%s_bin%0d", tag, i),  128'(got[i].bin),  128'(eq[i].bin));
      chk($sformatf("%s_fd%0d", tag, i),   128'(got[i].fd),   128'(eq[i].fd));
    end
  endtask

  initial begin
    // Reset state
    idle(3);
    chk("rst_ctl4",  128'({ov4, fd4, err4}), 128'(0));
    chk("rst_bin4",  128'(bin4), 128'(0));
    chk("rst_pool4", 128'(pool4), 128'(0));
    chk("rst_ctl24", 128'({ov24, fd24, err24}), 128'(0));
    rst = 1'b0;
    idle(2);

    // Ramp frame, thresholds zero
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 6; k++) fr[r][c][k] = r * 4 + c + k;
    for (int k = 0; k < 6; k++) thr[k] = 0;
    arm();
    for (int i = 0; i < 16; i++) send(i / 4, i % 4, 6'h3f);
    chk("ramp_last_ovalid", 128'(ov4), 128'(1));
    chk("ramp_last_fdone",  128'(fd4), 128'(1));
    idle(1);
    chk("ramp_ovalid_pulse", 128'(ov4), 128'(0));
    for (int i = 0; i < 4; i++)
      if (i < q4.size()) chk($sformatf("ramp_ch0_%0d", i), 128'(q4[i].pool[15:0]), 128'(ramp_exp[i]));
    model(4, 4);
    cmp("ramp", 1'b0);
    chk("ramp_err", 128'(err4), 128'(0));

    // Negative data: one -3 per window among -100s
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 6; k++) fr[r][c][k] = -100;
    for (int pr = 0; pr < 2; pr++)
      for (int pc = 0; pc < 2; pc++)
        for (int k = 0; k < 6; k++)
          fr[2*pr + int'($urandom_range(1))][2*pc + int'($urandom_range(1))][k] = -3;
    for (int k = 0; k < 6; k++) thr[k] = -50;
    arm();
    play(4, 4, 30);
    idle(2);
    if (q4.size() > 0) chk("neg_bin_const", 128'(q4[0].bin), 128'(6'h3f));
    model(4, 4);
    cmp("neg_t50", 1'b0);
    for (int k = 0; k < 6; k++) thr[k] = 0;
    arm();
    play(4, 4, 30);
    idle(2);
    if (q4.size() > 0) chk("neg0_bin_const", 128'(q4[0].bin), 128'(0));
    model(4, 4);
    cmp("neg_t0", 1'b0);

    // Threshold boundary: every window max is exactly 7
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 6; k++) fr[r][c][k] = int'($urandom_range(6));
    for (int pr = 0; pr < 2; pr++)
      for (int pc = 0; pc < 2; pc++)
        for (int k = 0; k < 6; k++)
          fr[2*pr + int'($urandom_range(1))][2*pc + int'($urandom_range(1))][k] = 7;
    for (int k = 0; k < 6; k++) thr[k] = (k % 2 == 0) ? 7 : 8;
    arm();
    play(4, 4, 0);
    idle(2);
    if (q4.size() > 0) chk("thr_bin_const", 128'(q4[0].bin), 128'(6'b010101));
    model(4, 4);
    cmp("thr", 1'b0);

    // Partial ivalid mid-frame: dropped, err set, counters undisturbed
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 6; k++) fr[r][c][k] = rnd16();
    for (int k = 0; k < 6; k++) thr[k] = rnd16();
    arm();
    for (int i = 0; i < 5; i++) send(i / 4, i % 4, 6'h3f);
    for (int k = 0; k < 6; k++) din[k] = 16'h7fff;
    ivalid = 6'b011111;
    @(negedge clk);
    ivalid = '0;
    chk("partial_err", 128'(err4), 128'(1));
    for (int i = 5; i < 16; i++) send(i / 4, i % 4, 6'h3f);
    idle(2);
    model(4, 4);
    cmp("partial", 1'b0);
    chk("partial_err_sticky", 128'(err4), 128'(1));
    arm();
    chk("start_clears_err", 128'(err4), 128'(0));

    // start with the 6th sample (first pooling position): sample dropped
    for (int i = 0; i < 5; i++) send(i / 4, i % 4, 6'h3f);
    start = 1'b1;
    send(1, 1, 6'h3f);
    start = 1'b0;
    chk("restart_no_ovalid", 128'(ov4), 128'(0));
    chk("restart_no_outputs", 128'(q4.size()), 128'(0));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 6; k++) fr[r][c][k] = rnd16();
    play(4, 4, 40);
    idle(2);
    model(4, 4);
    cmp("restart", 1'b0);

    // in_done before final sample: abort with err, later samples ignored
    arm();
    for (int i = 0; i < 3; i++) send(0, i, 6'h3f);
    in_done = 6'h3f;
    @(negedge clk);
    in_done = '0;
    chk("short_err", 128'(err4), 128'(1));
    play(4, 4, 0);
    idle(2);
    chk("short_no_outputs", 128'(q4.size()), 128'(0));

    // Full 24x24 random frame with ~50% gaps
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 24; c++)
        for (int k = 0; k < 6; k++) fr[r][c][k] = rnd16();
    for (int k = 0; k < 6; k++) thr[k] = rnd16();
    arm();
    q24.delete();
    play(24, 24, 50);
    idle(3);
    model(24, 24);
    cmp("rand24", 1'b1);
    chk("rand24_err", 128'(err24), 128'(0));
    q4.delete();

    // Asynchronous reset mid-frame clears outputs without waiting for a clock
    arm();
    play(24, 2, 0);
    ivalid = 6'b000001;
    @(negedge clk);
    ivalid = '0;
    #3 rst = 1'b1;
    #1;
    chk("arst_ctl",  128'({ov24, fd24, err24}), 128'(0));
    chk("arst_bin",  128'(bin24), 128'(0));
    chk("arst_pool", 128'(pool24), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
